// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - I/D single-port memory arbiter with watchdog; optional macro ARB_ROUND_ROBIN_EN
module mem_port_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          timeout_err,
  output logic          busy
);

  // Watchdog counts 0..TIMEOUT-1 cycles of mem_req high
  localparam int WDW = $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    I_ACC = 2'd1,
    D_ACC = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t         state;
  logic [WDW-1:0] wd_cnt;
  logic           grant_d;
  logic           grant_i;

`ifdef ARB_ROUND_ROBIN_EN
  // 0 = I-port served last, 1 = D-port served last
  logic last_grant;

  // On a tie, serve the port that was not served last
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (d_req && (!if_req || !last_grant)) begin
      grant_d = 1'b1;
    end else if (if_req) begin
      grant_i = 1'b1;
    end
  end
`else
  // Fixed priority: the data port always wins a tie
  always_comb begin
    grant_d = d_req;
    grant_i = if_req & ~d_req;
  end
`endif

  // Access sequencer: grant, hold memory request, then one response cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wd_cnt      <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      if_rdata    <= '0;
      d_rdata     <= '0;
      if_valid    <= 1'b0;
      d_valid     <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= D_ACC;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            wd_cnt    <= '0;
            busy      <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= 1'b1;
`endif
          end else if (grant_i) begin
            state    <= I_ACC;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
            wd_cnt   <= '0;
            busy     <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= 1'b0;
`endif
          end
        end
        I_ACC, D_ACC: begin
          wd_cnt <= wd_cnt + WDW'(1);
          if (mem_ack) begin
            state   <= RESP;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (state == I_ACC) begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdata;
            end else begin
              d_valid <= 1'b1;
              // Writes leave the last read data visible to the D-port
              if (!mem_we) begin
                d_rdata <= mem_rdata;
              end
            end
          end else if (wd_cnt == WD_LAST) begin
            // Hung access: abort and hand back zero data
            state       <= RESP;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            timeout_err <= 1'b1;
            if (state == I_ACC) begin
              if_valid <= 1'b1;
              if_rdata <= '0;
            end else begin
              d_valid <= 1'b1;
              d_rdata <= '0;
            end
          end
        end
        RESP: begin
          if_valid <= 1'b0;
          d_valid  <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state    <= IDLE;
          mem_req  <= 1'b0;
          if_valid <= 1'b0;
          d_valid  <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter (default fixed-priority build)
module tb_mem_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_valid;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          timeout_err;
  logic          busy;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference: one outstanding access, age in cycles of mem_req high
  bit          m_active, m_resp, m_vi, m_vd, m_terr, m_port, m_we;
  int          m_age;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata, m_if_rdata, m_d_rdata;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 0; m_resp = 0; m_vi = 0; m_vd = 0; m_terr = 0;
      m_if_rdata = 0; m_d_rdata = 0; m_age = 0;
    end else if (m_resp) begin
      m_resp = 0; m_vi = 0; m_vd = 0;
    end else if (m_active) begin
      if (mem_ack) begin
        m_active = 0; m_resp = 1;
        if (m_port) begin
          m_vd = 1;
          if (!m_we) m_d_rdata = mem_rdata;
        end else begin
          m_vi = 1;
          m_if_rdata = mem_rdata;
        end
      end else if (m_age == TIMEOUT) begin
        m_active = 0; m_resp = 1; m_terr = 1;
        if (m_port) begin m_vd = 1; m_d_rdata = 0; end
        else begin m_vi = 1; m_if_rdata = 0; end
      end else begin
        m_age = m_age + 1;
      end
    end else if (d_req || if_req) begin
      m_active = 1; m_age = 1;
      m_port  = d_req;
      m_addr  = d_req ? d_addr : if_addr;
      m_we    = d_req & d_we;
      m_wdata = d_wdata;
    end
  end

  // Every-cycle comparison against the reference
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mdl_mem_req", mem_req, m_active);
      chk("mdl_busy", busy, m_active | m_resp);
      chk("mdl_if_valid", if_valid, m_vi);
      chk("mdl_d_valid", d_valid, m_vd);
      chk("mdl_timeout_err", timeout_err, m_terr);
      chk("mdl_if_rdata", if_rdata, m_if_rdata);
      chk("mdl_d_rdata", d_rdata, m_d_rdata);
      chk("two_valids", if_valid & d_valid, 0);
      if (m_active) begin
        chk("mdl_mem_addr", mem_addr, m_addr);
        chk("mdl_mem_we", mem_we, m_we);
        if (m_port) chk("mdl_mem_wdata", mem_wdata, m_wdata);
      end
    end
  end

  logic [31:0] bmem [256];
  int i_iss, i_done, d_iss, d_done, lat, cnt, hi, n_ord;
  bit prev_req, got;
  bit ord [4];

  task automatic drive_cycle(input bit issue_en);
    if (if_valid) begin
      chk("rnd_if_valid_held", if_req, 1);
      if (if_req) begin
        chk("rnd_if_rdata", if_rdata, bmem[if_addr]);
        i_done++;
        if_req = 0;
      end
    end
    if (d_valid) begin
      chk("rnd_d_valid_held", d_req, 1);
      if (d_req) begin
        if (!d_we) chk("rnd_d_rdata", d_rdata, bmem[d_addr]);
        d_done++;
        d_req = 0;
      end
    end
    if (issue_en && !if_req && ($urandom % 3 == 0)) begin
      if_req = 1; if_addr = 8'($urandom); i_iss++;
    end
    if (issue_en && !d_req && ($urandom % 3 == 0)) begin
      d_req = 1; d_we = 1'($urandom); d_addr = 8'($urandom); d_wdata = $urandom; d_iss++;
    end
    if (mem_req) begin
      if (!prev_req) begin lat = $urandom_range(0, 5); cnt = 0; end
      if (cnt == lat) begin
        mem_ack = 1;
        if (mem_we) begin bmem[mem_addr] = mem_wdata; mem_rdata = $urandom; end
        else mem_rdata = bmem[mem_addr];
      end else begin
        mem_ack = 0; cnt++;
      end
    end else begin
      mem_ack = ($urandom % 4 == 0);
      mem_rdata = $urandom;
    end
    prev_req = mem_req;
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    step(); step();
    rst = 0;
    chk_en = 1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_rdata", if_rdata | d_rdata, 0);

    // Test 1: fetch read, ack one cycle after mem_req
    if_req = 1; if_addr = 8'h04;
    step();
    chk("t1_mem_req", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 8'h04);
    chk("t1_mem_we", mem_we, 0);
    step();
    mem_ack = 1; mem_rdata = 32'h2002000A;
    step();
    mem_ack = 0;
    chk("t1_if_valid", if_valid, 1);
    chk("t1_if_rdata", if_rdata, 32'h2002000A);
    if_req = 0;
    step();
    chk("t1_if_valid_pulse", if_valid, 0);

    // Test 2: data write, ack held off three cycles
    d_req = 1; d_we = 1; d_addr = 8'h10; d_wdata = 32'hCAFE0001;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_mem_req", mem_req, 1);
      chk("t2_mem_we", mem_we, 1);
      chk("t2_mem_wdata", mem_wdata, 32'hCAFE0001);
      chk("t2_mem_addr", mem_addr, 8'h10);
      if (i == 3) mem_ack = 1;
    end
    step();
    mem_ack = 0;
    chk("t2_d_valid", d_valid, 1);
    chk("t2_d_rdata", d_rdata, 0);
    d_req = 0;
    step();
    chk("t2_d_valid_pulse", d_valid, 0);

    // Test 3: simultaneous requests, D first then I
    if_req = 1; if_addr = 8'h20; d_req = 1; d_we = 0; d_addr = 8'h30;
    mem_ack = 1; mem_rdata = 32'h12345678; n_ord = 0;
    for (int c = 0; c < 20 && n_ord < 2; c++) begin
      step();
      if (d_valid) begin
        chk("t3_d_rdata", d_rdata, 32'h12345678);
        ord[n_ord] = 1; n_ord++; d_req = 0;
      end
      if (if_valid) begin ord[n_ord] = 0; n_ord++; if_req = 0; end
    end
    mem_ack = 0;
    chk("t3_count", n_ord, 2);
    chk("t3_first_is_d", ord[0], 1);
    chk("t3_second_is_i", ord[1], 0);
    step();

    // Test 4: watchdog abort on a hung read
    d_req = 1; d_we = 0; d_addr = 8'h40; hi = 0; got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      step();
      if (mem_req) hi++;
      if (d_valid) begin
        got = 1;
        chk("t4_d_rdata", d_rdata, 0);
        d_req = 0;
      end
    end
    chk("t4_got_valid", got, 1);
    chk("t4_req_cycles", hi, 16);
    chk("t4_timeout_err", timeout_err, 1);
    step(); step(); step();
    chk("t4_timeout_sticky", timeout_err, 1);

    // Test 5: reset one cycle into D_ACC, then re-issue
    d_req = 1; d_we = 0; d_addr = 8'h50;
    step();
    chk("t5_in_acc", mem_req, 1);
    rst = 1;
    step();
    rst = 0;
    chk("t5_mem_req", mem_req, 0);
    chk("t5_busy", busy, 0);
    chk("t5_d_valid", d_valid, 0);
    chk("t5_timeout_clr", timeout_err, 0);
    got = 0; mem_rdata = 32'h5050A5A5;
    for (int c = 0; c < 20 && !got; c++) begin
      step();
      if (d_valid) begin
        got = 1;
        chk("t5_d_rdata", d_rdata, 32'h5050A5A5);
        d_req = 0;
      end
      mem_ack = mem_req;
    end
    chk("t5_reissue_done", got, 1);
    mem_ack = 0;
    step(); step();

    // Test 6: random traffic
    for (int i = 0; i < 256; i++) bmem[i] = $urandom;
    i_iss = 0; i_done = 0; d_iss = 0; d_done = 0; prev_req = 0; lat = 0; cnt = 0;
    for (int cyc = 0; cyc < 30000 && (i_done + d_done) < 1000; cyc++) begin
      step();
      drive_cycle(1);
    end
    for (int cyc = 0; cyc < 200 && (if_req || d_req); cyc++) begin
      step();
      drive_cycle(0);
    end
    chk("rnd_total", ((i_done + d_done) >= 1000), 1);
    chk("rnd_if_all_served", i_done, i_iss);
    chk("rnd_d_all_served", d_done, d_iss);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
